// File: rtl/onehot_pulse_decoder.sv
// Registered 4-to-16 one-hot pulse decoder with a valid/ready input handshake.
// An accepted binary index drives its one-hot line for a programmable number
// of cycles, then releases it with a one-cycle done pulse.
// Optional feature macro: DECODER_SCAN_EN adds a scan_start port and a SCAN
// state that walks all 16 lines in order, one effective hold period each.
module onehot_pulse_decoder #(
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        binary_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HOLD_W-1:0] hold_cycles,
`ifdef DECODER_SCAN_EN
  input  logic              scan_start,
`endif
  output logic [15:0]       decoder_out,
  output logic              out_valid,
  output logic              done
);

  localparam int unsigned OUT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] count_q, count_d;
  logic [OUT_W-1:0]  dec_d;
  logic              out_valid_d;
  logic              done_d;
  logic [HOLD_W-1:0] eff_hold_c;
  logic              accept_c;
`ifdef DECODER_SCAN_EN
  logic [HOLD_W-1:0] scan_hold_q, scan_hold_d;
`endif

  // A zero hold request still produces a one-cycle pulse.
  assign eff_hold_c = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign in_ready   = enable && (state_q == S_IDLE);
  assign accept_c   = in_valid && in_ready;

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      decoder_out <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
`ifdef DECODER_SCAN_EN
      scan_hold_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      decoder_out <= dec_d;
      out_valid   <= out_valid_d;
      done        <= done_d;
`ifdef DECODER_SCAN_EN
      scan_hold_q <= scan_hold_d;
`endif
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dec_d       = decoder_out;
    out_valid_d = out_valid;
    done_d      = 1'b0;
`ifdef DECODER_SCAN_EN
    scan_hold_d = scan_hold_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d     = S_HOLD;
          count_d     = eff_hold_c;
          dec_d       = OUT_W'(16'h0001) << binary_in;
          out_valid_d = 1'b1;
        end
`ifdef DECODER_SCAN_EN
        else if (in_ready && scan_start) begin
          state_d     = S_SCAN;
          count_d     = eff_hold_c;
          scan_hold_d = eff_hold_c;
          dec_d       = OUT_W'(16'h0001);
          out_valid_d = 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (!enable) begin
          state_d     = S_IDLE;
          count_d     = '0;
          dec_d       = '0;
          out_valid_d = 1'b0;
        end else if (count_q == HOLD_W'(1)) begin
          state_d     = S_IDLE;
          count_d     = '0;
          dec_d       = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          count_d = count_q - HOLD_W'(1);
        end
      end
`ifdef DECODER_SCAN_EN
      S_SCAN: begin
        if (!enable) begin
          state_d     = S_IDLE;
          count_d     = '0;
          dec_d       = '0;
          out_valid_d = 1'b0;
        end else if (count_q == HOLD_W'(1)) begin
          if (decoder_out[OUT_W-1]) begin
            state_d     = S_IDLE;
            count_d     = '0;
            dec_d       = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            count_d = scan_hold_q;
            dec_d   = decoder_out << 1;
          end
        end else begin
          count_d = count_q - HOLD_W'(1);
        end
      end
`endif
      default: begin
        state_d     = S_IDLE;
        count_d     = '0;
        dec_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed self-checking bench for onehot_pulse_decoder.
module tb_onehot_pulse_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  binary_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  hold_cycles;
  logic        scan_start;
  logic [15:0] decoder_out;
  logic        out_valid;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.HOLD_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .binary_in   (binary_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .hold_cycles (hold_cycles),
`ifdef DECODER_SCAN_EN
    .scan_start  (scan_start),
`endif
    .decoder_out (decoder_out),
    .out_valid   (out_valid),
    .done        (done)
  );

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [15:0] exp_dec,
                            input logic exp_ov, input logic exp_done,
                            input logic exp_rdy);
    n_cmp++;
    if (decoder_out !== exp_dec || out_valid !== exp_ov || done !== exp_done ||
        in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL %s: got dec=%h ov=%b done=%b rdy=%b, want dec=%h ov=%b done=%b rdy=%b",
               name, decoder_out, out_valid, done, in_ready,
               exp_dec, exp_ov, exp_done, exp_rdy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; binary_in = '0;
    hold_cycles = '0; scan_start = 1'b0;
    tick(); tick();
    check_outs("reset_state", 16'h0000, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    // Reset mid-pulse
    binary_in = 4'd9; hold_cycles = 8'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_outs("mid_accept", 16'h0200, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outs("reset_mid_pulse", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    check_outs("reset_no_done", 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    binary_in = 4'd3; hold_cycles = 8'd3; in_valid = 1'b1;
    #1;
    check_outs("basic_ready", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_outs("basic_hold", 16'h0008, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_outs("basic_done", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("basic_done_clr", 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_zero_hold_extremes();
    binary_in = 4'd0; hold_cycles = 8'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_outs("zero_hold_pulse", 16'h0001, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("zero_hold_done", 16'h0000, 1'b0, 1'b1, 1'b1);
    binary_in = 4'd15; hold_cycles = 8'd255; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 255; i++) begin
      check_outs("max_hold", 16'h8000, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_outs("max_hold_done", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    binary_in = 4'd7; hold_cycles = 8'd2; in_valid = 1'b1;
    tick();
    check_outs("b2b_first_0", 16'h0080, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("b2b_first_1", 16'h0080, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("b2b_gap", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("b2b_second_0", 16'h0080, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check_outs("b2b_second_1", 16'h0080, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("b2b_second_done", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_abort();
    binary_in = 4'd12; hold_cycles = 8'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_outs("abort_pulse", 16'h1000, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    enable = 1'b0;
    #1;
    check_outs("abort_ready_low", 16'h1000, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("abort_cleared", 16'h0000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_outs("abort_idle_disabled", 16'h0000, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    enable = 1'b1;
    #1;
    check_outs("abort_reenable", 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

`ifdef DECODER_SCAN_EN
  task automatic test_scan();
    logic [15:0] exp;
    hold_cycles = 8'd2; scan_start = 1'b1; in_valid = 1'b0;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp = 16'h0001 << k;
      for (int j = 0; j < 2; j++) begin
        if (k == 5) begin
          in_valid = 1'b1; binary_in = 4'd3; #0;
        end else begin
          in_valid = 1'b0;
        end
        check_outs("scan_walk", exp, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    in_valid = 1'b0;
    check_outs("scan_done", 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("scan_done_clr", 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_hold_extremes();
    test_back_to_back();
    test_abort();
`ifdef DECODER_SCAN_EN
    test_scan();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
